// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser, debounce counter, stable
// level with single-cycle press/release pulses and an optional long-press flag.
module debounce_bank #(
    parameter int unsigned       NUM_CH            = 4,
    parameter int unsigned       DEBOUNCE_INTERVAL = 4000000,
    parameter int unsigned       SYNC_STAGES       = 2,
    parameter int unsigned       HOLD_INTERVAL     = 0,
    parameter logic [NUM_CH-1:0] INVERT            = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] btn_i,
    output logic [NUM_CH-1:0] btn_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] hold_o
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_INTERVAL);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   cand_q;
        logic [CW-1:0]          cnt_q;
        logic                   btn_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   accept;

        assign s      = sync_q[SYNC_STAGES-1];
        // A candidate is accepted only after it has been steady for the full interval.
        assign accept = (s == cand_q) && (cnt_q == CNT_MAX) && (cand_q != btn_q);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '0;
                cand_q <= 1'b0;
                cnt_q  <= '0;
                btn_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[i] ^ INVERT[i]};
                rise_q <= accept && cand_q;
                fall_q <= accept && !cand_q;
                if (s != cand_q) begin
                    cand_q <= s;
                    cnt_q  <= '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (accept) begin
                    btn_q <= cand_q;
                end
            end
        end

        assign btn_o[i]  = btn_q;
        assign rise_o[i] = rise_q;
        assign fall_o[i] = fall_q;

        if (HOLD_INTERVAL > 0) begin : g_hold
            localparam int unsigned   HW       = $clog2(HOLD_INTERVAL + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_INTERVAL);

            logic [HW-1:0] hcnt_q;
            logic [HW-1:0] hcnt_d;
            logic          btn_d;
            logic          hold_q;

            // Look at next-cycle values so hold drops on the very edge btn_o falls.
            always_comb begin
                btn_d  = accept ? cand_q : btn_q;
                hcnt_d = hcnt_q;
                if (!btn_q || (accept && cand_q)) begin
                    hcnt_d = '0;
                end else if (hcnt_q < HOLD_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hcnt_q <= '0;
                    hold_q <= 1'b0;
                end else begin
                    hcnt_q <= hcnt_d;
                    hold_q <= btn_d && (hcnt_d == HOLD_MAX);
                end
            end

            assign hold_o[i] = hold_q;
        end else begin : g_no_hold
            assign hold_o[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised scoreboard bench for debounce_bank: a sliding-window model of the
// synchronised input predicts every cycle's outputs, a monitor compares them.
module tb_debounce_bank;

    localparam int         NCH = 2;
    localparam int         DI  = 4;
    localparam int         SS  = 2;
    localparam int         HI  = 10;
    localparam logic [1:0] INV = 2'b10;
    localparam int         WIN = DI + 2;

    typedef struct packed {
        logic [1:0] btn;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] hold;
    } exp_t;

    logic       clk_i;
    logic       rst_ni;
    logic [1:0] btn_i;
    logic [1:0] btn_o;
    logic [1:0] rise_o;
    logic [1:0] fall_o;
    logic [1:0] hold_o;

    exp_t exp_q[$];
    int   tests;
    int   failures;

    logic [WIN+1:0] hist [NCH];
    logic [1:0]     m_btn;
    int             held [NCH];

    debounce_bank #(
        .NUM_CH           (NCH),
        .DEBOUNCE_INTERVAL(DI),
        .SYNC_STAGES      (SS),
        .HOLD_INTERVAL    (HI),
        .INVERT           (INV)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .btn_i (btn_i),
        .btn_o (btn_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .hold_o(hold_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task modelClear();
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch] = '0;
            held[ch] = 0;
        end
        m_btn = '0;
    endtask

    // The level becomes the output once the last WIN synchronised samples agree.
    task modelEdge(input logic [1:0] b);
        exp_t e;
        e = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            logic lvl;
            bit   stable;
            hist[ch] = {hist[ch][WIN:0], b[ch] ^ INV[ch]};
            lvl      = hist[ch][SS];
            stable   = 1'b1;
            for (int k = SS; k < SS + WIN; k++) begin
                if (hist[ch][k] != lvl) stable = 1'b0;
            end
            if (stable && (lvl != m_btn[ch])) begin
                m_btn[ch] = lvl;
                if (lvl) e.rise[ch] = 1'b1;
                else     e.fall[ch] = 1'b1;
                held[ch] = 0;
            end else if (m_btn[ch] && (held[ch] < HI)) begin
                held[ch]++;
            end
            e.btn[ch]  = m_btn[ch];
            e.hold[ch] = m_btn[ch] && (held[ch] >= HI);
        end
        exp_q.push_back(e);
    endtask

    task applyStimulus(input logic [1:0] b, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            btn_i = b;
            @(posedge clk_i);
            modelEdge(b);
            #1;
        end
    endtask

    task applyReset(input int cycles);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        modelClear();
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk_i);
            exp_q.push_back('0);
        end
        #1;
        rst_ni = 1'b1;
    endtask

    task checkOutput(input string name, input logic [1:0] act, input logic [1:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("btn_o",  btn_o,  e.btn);
            checkOutput("rise_o", rise_o, e.rise);
            checkOutput("fall_o", fall_o, e.fall);
            checkOutput("hold_o", hold_o, e.hold);
        end
    end

    initial begin
        tests    = 0;
        failures = 0;
        rst_ni   = 1'b0;
        btn_i    = 2'b10;
        modelClear();

        applyReset(3);
        applyStimulus(2'b10, 12);

        applyStimulus(2'b11, 30);
        applyStimulus(2'b10, 15);

        applyStimulus(2'b11, 3);
        applyStimulus(2'b10, 12);
        for (int n = 0; n < 10; n++) begin
            applyStimulus(2'b11, 2);
            applyStimulus(2'b10, 2);
        end
        applyStimulus(2'b10, 12);

        applyStimulus(2'b00, 2);
        applyStimulus(2'b01, 20);
        applyStimulus(2'b10, 15);

        applyStimulus(2'b11, 5);
        applyReset(3);
        applyStimulus(2'b11, 14);
        applyStimulus(2'b10, 12);

        for (int seg = 0; seg < 70; seg++) begin
            logic [1:0] val;
            int         len;
            val = 2'($urandom);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 25) : $urandom_range(1, 8);
            applyStimulus(val, len);
            if ($urandom_range(0, 40) == 0) applyReset($urandom_range(1, 3));
        end
        applyStimulus(2'b10, 20);

        repeat (3) @(negedge clk_i);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
